// File: rtl/cpu_ctrl.sv
// Multi-cycle fetch/decode/sequencing controller for the 16-bit lab processor.
// Owns PC, IR and a 16x16 register file; drives an external ALU and commits its results.
module cpu_ctrl #(
  parameter int PC_W  = 8,
  parameter int NREGS = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_rdata,
  output logic [15:0]     alu_a,
  output logic [15:0]     alu_b,
  output logic [3:0]      alu_s,
  input  logic [15:0]     alu_f,
  input  logic            alu_ovf,
  input  logic            alu_take_branch,
  output logic [PC_W-1:0] pc,
  output logic [2:0]      state_o,
  output logic            halted,
  output logic            ovf_sticky,
  input  logic [3:0]      dbg_addr,
  output logic [15:0]     dbg_data
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALTED    = 3'd5
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_BEQ  = 4'h6;
  localparam logic [3:0] OP_BNE  = 4'h7;
  localparam logic [3:0] OP_XOR  = 4'h8;
  localparam logic [3:0] OP_LDI  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t          state;
  logic [15:0]     ir;
  logic [15:0]     result_q;
  logic            branch_q;
  logic            ovf_q;
  logic [15:0]     regs [NREGS];

  logic [3:0]      op, rd, rs, rt;
  logic [PC_W-1:0] pc_inc, pc_br;
  logic [15:0]     imm16;

  assign op     = ir[15:12];
  assign rd     = ir[11:8];
  assign rs     = ir[7:4];
  assign rt     = ir[3:0];
  assign imm16  = {{8{ir[7]}}, ir[7:0]};
  assign pc_inc = pc + PC_W'(1);
  assign pc_br  = pc_inc + PC_W'($signed(ir[7:0]));

  function automatic logic is_alu_op(input logic [3:0] o);
    return (o <= 4'd5) || (o == OP_XOR);
  endfunction

  // Memory is synchronous: the word for imem_addr presented in FETCH arrives in DECODE.
  assign imem_addr = pc;
  assign state_o   = state;
  assign halted    = (state == S_HALTED);
  assign dbg_data  = regs[dbg_addr];

  // ALU inputs are live only in EXECUTE so result_q captures the ALU in the same cycle.
  always_comb begin
    alu_a = '0;
    alu_b = '0;
    alu_s = '0;
    if (state == S_EXECUTE) begin
      if (is_alu_op(op)) begin
        alu_s = op;
        alu_a = regs[rs];
        alu_b = regs[rt];
      end else if (op == OP_BEQ || op == OP_BNE) begin
        alu_s = op;
        alu_a = regs[rd];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pc         <= '0;
      ir         <= '0;
      result_q   <= '0;
      branch_q   <= 1'b0;
      ovf_q      <= 1'b0;
      ovf_sticky <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_IDLE: if (run) state <= S_FETCH;
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          ir    <= imem_rdata;
          state <= S_EXECUTE;
        end
        S_EXECUTE: begin
          result_q <= alu_f;
          branch_q <= alu_take_branch;
          ovf_q    <= alu_ovf;
          state    <= (op == OP_HALT) ? S_HALTED : S_WRITEBACK;
        end
        S_WRITEBACK: begin
          if (is_alu_op(op)) begin
            regs[rd] <= result_q;
            pc       <= pc_inc;
            if (op == OP_ADD) ovf_sticky <= ovf_sticky | ovf_q;
          end else if (op == OP_BEQ || op == OP_BNE) begin
            pc <= branch_q ? pc_br : pc_inc;
          end else if (op == OP_LDI) begin
            regs[rd] <= imm16;
            pc       <= pc_inc;
          end else if (op != OP_HALT) begin
            pc <= pc_inc;
          end
          state <= run ? S_FETCH : S_IDLE;
        end
        S_HALTED: state <= S_HALTED;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule
